seq_key_search: RTL and testbench

- Sequential lookup controller that owns a DEPTH-entry table of 11-bit keys.
- It shares one 11-bit equality comparator across all entries, comparing one entry per cycle.
- It accepts a search key over a valid/ready handshake, scans entries from index 0 upward, and returns hit/index over a second valid/ready handshake.
- Used for opcode and tag matching where area matters more than lookup latency.

---
 rtl/seq_key_search_pkg.sv | 24 ++
 rtl/comparator_11bit.sv | 27 ++
 rtl/seq_key_search.sv | 134 +++++++++++++
 tb/tb_seq_key_search.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_key_search_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_key_search_pkg
// Description : Shared types and constants for the sequential key search
//               controller: key width, FSM state encoding, table entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_key_search_pkg;

    localparam int KEY_W = 11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [KEY_W-1:0] key;
    } entry_t;

endpackage : seq_key_search_pkg
`default_nettype wire

// File: rtl/comparator_11bit.sv
`default_nettype none
// ============================================================================
// Module      : comparator_11bit
// Description : Structural 11-bit equality comparator. One per-bit XNOR
//               stage followed by an AND reduction.
// Ports       : a, b  - operands (KEY_W bits)
//               eq    - 1 when a == b
// Revision    : 1.0 - initial release
// ============================================================================
module comparator_11bit
    import seq_key_search_pkg::*;
(
    input  logic [KEY_W-1:0] a,
    input  logic [KEY_W-1:0] b,
    output logic             eq
);

    logic [KEY_W-1:0] bit_eq;

    for (genvar i = 0; i < KEY_W; i++) begin : g_bit
        assign bit_eq[i] = ~(a[i] ^ b[i]);
    end

    assign eq = &bit_eq;

endmodule : comparator_11bit
`default_nettype wire

// File: rtl/seq_key_search.sv
`default_nettype none
// ============================================================================
// Module      : seq_key_search
// Description : Sequential lookup controller over a DEPTH-entry key table.
//               A single shared comparator checks one entry per cycle,
//               scanning upward from index 0; the first valid match wins.
// Ports       : clk, rst_n            - clock, async active-low reset
//               wr_en/wr_idx/wr_key/wr_valid - table write port
//               req_valid/req_ready/req_key  - search request handshake
//               rsp_valid/rsp_ready/rsp_hit/rsp_idx - result handshake
//               busy                  - high in SEARCH or RESP
// Revision    : 1.0 - initial release
// ============================================================================
module seq_key_search
    import seq_key_search_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [KEY_W-1:0] wr_key,
    input  logic             wr_valid,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [KEY_W-1:0] req_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic [IDX_W-1:0] rsp_idx,
    output logic             busy
);

    state_t           state;
    state_t           next_state;
    entry_t           tbl [DEPTH];
    logic [KEY_W-1:0] key_q;
    logic [IDX_W-1:0] ptr;

    entry_t cur_entry;
    logic   key_eq;
    logic   match;
    logic   last;
    logic   accept;

    // Combinational read returns the pre-edge contents, so a write landing on
    // the entry under comparison is not seen until a later scan.
    assign cur_entry = tbl[ptr];
    assign last      = (ptr == IDX_W'(DEPTH - 1));
    assign match     = key_eq & cur_entry.valid;

    comparator_11bit u_cmp (
        .a  (key_q),
        .b  (cur_entry.key),
        .eq (key_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        // Gated by rst_n so the requester sees not-ready while reset is held.
        req_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                busy      = 1'b0;
                req_ready = rst_n;
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (match || last) begin
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '0;
            ptr     <= '0;
            rsp_hit <= 1'b0;
            rsp_idx <= '0;
        end else if (accept) begin
            key_q <= req_key;
            ptr   <= '0;
        end else if (state == S_SEARCH) begin
            if (match) begin
                rsp_hit <= 1'b1;
                rsp_idx <= ptr;
            end else if (last) begin
                rsp_hit <= 1'b0;
                rsp_idx <= '0;
            end else begin
                ptr <= ptr + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (wr_en && (int'(wr_idx) < DEPTH)) begin
            tbl[wr_idx] <= '{valid: wr_valid, key: wr_key};
        end
    end

endmodule : seq_key_search
`default_nettype wire

// File: tb/tb_seq_key_search.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_key_search
// Description : Self-checking bench for seq_key_search (DEPTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_key_search;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;
    localparam int LIMIT = 100;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [IDX_W-1:0] wr_idx = '0;
    logic [10:0]      wr_key = '0;
    logic             wr_valid = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [10:0]      req_key = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic             rsp_hit;
    logic [IDX_W-1:0] rsp_idx;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_key_search #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_key    (wr_key),
        .wr_valid  (wr_valid),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_key   (req_key),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_idx   (rsp_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0]      key;
        logic             hit;
        logic [IDX_W-1:0] idx;
        int               lat;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_entry(input int idx, input logic v, input logic [10:0] k);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_idx   = IDX_W'(idx);
        wr_valid = v;
        wr_key   = k;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic clear_table();
        for (int i = 0; i < DEPTH; i++) write_entry(i, 1'b0, 11'h000);
    endtask

    // Returns #1 after the accept edge (state SEARCH, ptr = 0).
    task automatic start_search(input logic [10:0] k);
        @(negedge clk);
        req_valid = 1'b1;
        req_key   = k;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Counts edges from 'start' until rsp_valid, checking busy on the way.
    task automatic wait_rsp(input int start, output int lat);
        int n;
        n = start;
        while (!rsp_valid && n < LIMIT) begin
            if (!busy) begin
                n_checks++;
                n_fail++;
                $display("FAIL busy_during_search: got 0 expected 1 at edge %0d", n);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!rsp_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid 0 after %0d edges expected 1", n);
        end
        lat = n;
    endtask

    task automatic take_rsp(input string name);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({name, "_valid_cleared"}, int'(rsp_valid), 0);
        chk({name, "_req_ready"}, int'(req_ready), 1);
    endtask

    task automatic check_search(input string name, input logic [10:0] k,
                                input logic hit, input int idx, input int lat);
        int got;
        start_search(k);
        wait_rsp(0, got);
        chk({name, "_lat"}, got, lat);
        chk({name, "_hit"}, int'(rsp_hit), int'(hit));
        chk({name, "_idx"}, int'(rsp_idx), idx);
        chk({name, "_busy"}, int'(busy), 1);
        take_rsp(name);
    endtask

    // Writes one entry while ptr == wptr, then checks the result.
    task automatic mid_write_search(input string name, input logic [10:0] k,
                                    input int wptr, input int widx,
                                    input logic hit, input int idx, input int lat);
        int got;
        start_search(k);
        for (int i = 0; i < wptr; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        wr_en    = 1'b1;
        wr_idx   = IDX_W'(widx);
        wr_valid = 1'b1;
        wr_key   = k;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        wait_rsp(wptr + 1, got);
        chk({name, "_lat"}, got, lat);
        chk({name, "_hit"}, int'(rsp_hit), int'(hit));
        chk({name, "_idx"}, int'(rsp_idx), idx);
        take_rsp(name);
    endtask

    initial begin
        int got;

        vecs[0] = '{key: 11'h5A1, hit: 1'b1, idx: 3'd3, lat: 4};
        vecs[1] = '{key: 11'h123, hit: 1'b1, idx: 3'd2, lat: 3};
        vecs[2] = '{key: 11'h7FF, hit: 1'b0, idx: 3'd0, lat: 8};
        vecs[3] = '{key: 11'h000, hit: 1'b0, idx: 3'd0, lat: 8};
        vecs[4] = '{key: 11'h5A0, hit: 1'b0, idx: 3'd0, lat: 8};

        // Reset values
        #12;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_hit", int'(rsp_hit), 0);
        chk("rst_rsp_idx", int'(rsp_idx), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", int'(req_ready), 1);

        write_entry(3, 1'b1, 11'h5A1);
        write_entry(2, 1'b1, 11'h123);
        write_entry(6, 1'b1, 11'h123);
        write_entry(5, 1'b0, 11'h7FF);

        for (int v = 0; v < 5; v++) begin
            check_search($sformatf("vec%0d", v), vecs[v].key, vecs[v].hit,
                         int'(vecs[v].idx), vecs[v].lat);
        end

        // Writes during a scan
        clear_table();
        mid_write_search("ahead_write", 11'h0F0, 1, 4, 1'b1, 4, 5);
        clear_table();
        mid_write_search("behind_write", 11'h0F0, 1, 0, 1'b0, 0, 8);
        clear_table();
        mid_write_search("same_ptr_write", 11'h0F0, 3, 3, 1'b0, 0, 8);

        // Response backpressure
        clear_table();
        write_entry(3, 1'b1, 11'h5A1);
        start_search(11'h5A1);
        wait_rsp(0, got);
        chk("bp_lat", got, 4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_hit", int'(rsp_hit), 1);
            chk("bp_idx", int'(rsp_idx), 3);
            chk("bp_req_ready", int'(req_ready), 0);
        end
        take_rsp("bp");
        chk("bp_busy_idle", int'(busy), 0);

        // Asynchronous reset while scanning at ptr = 2
        start_search(11'h5A1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        chk("pre_arst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_req_ready", int'(req_ready), 0);
        chk("arst_rsp_valid", int'(rsp_valid), 0);
        chk("arst_rsp_hit", int'(rsp_hit), 0);
        chk("arst_rsp_idx", int'(rsp_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_search("post_arst", 11'h5A1, 1'b0, 0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_key_search
`default_nettype wire
